// File: rtl/ofdm_pkg.sv
// rtl/ofdm_pkg.sv - shared OFDM framing constants and CFO sequencer state encoding
package ofdm_pkg;

    localparam int DATA_W  = 16;
    localparam int NFFT    = 64;
    localparam int NCP     = 16;
    localparam int SYM_LEN = NFFT + NCP;
    localparam int Q_FRAC  = 11;    // eps values are Q5.11

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        WAIT_RES = 3'd2,
        DONE     = 3'd3,
        ERR      = 3'd4
    } seq_state_t;

endpackage

// File: rtl/cfo_est_sequencer_if.sv
// rtl/cfo_est_sequencer_if.sv - sample stream, estimator link and result signals of the CFO sequencer
interface cfo_est_sequencer_if
    import ofdm_pkg::*;
;
    logic                     start;
    logic [1:0]               cfg_log2_nsym;
    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_rx1_re, s_rx1_im, s_rx2_re, s_rx2_im;
    logic                     est_in_valid;
    logic                     est_symbol_start;
    logic signed [DATA_W-1:0] est_rx1_re, est_rx1_im, est_rx2_re, est_rx2_im;
    logic                     est_cfo_valid;
    logic signed [DATA_W-1:0] est_cfo_eps;
    logic                     avg_valid;
    logic signed [DATA_W-1:0] avg_eps;
    logic                     busy;
    logic                     err_timeout;

    // master is the sequencer; slave is the upstream/estimator/compensator environment
    modport master (
        input  start, cfg_log2_nsym, s_valid, s_rx1_re, s_rx1_im, s_rx2_re, s_rx2_im,
        input  est_cfo_valid, est_cfo_eps,
        output s_ready, est_in_valid, est_symbol_start,
        output est_rx1_re, est_rx1_im, est_rx2_re, est_rx2_im,
        output avg_valid, avg_eps, busy, err_timeout
    );

    modport slave (
        output start, cfg_log2_nsym, s_valid, s_rx1_re, s_rx1_im, s_rx2_re, s_rx2_im,
        output est_cfo_valid, est_cfo_eps,
        input  s_ready, est_in_valid, est_symbol_start,
        input  est_rx1_re, est_rx1_im, est_rx2_re, est_rx2_im,
        input  avg_valid, avg_eps, busy, err_timeout
    );

endinterface

// File: rtl/cfo_avg_acc.sv
// rtl/cfo_avg_acc.sv - clear/add accumulator that shifts out the floor average of per-symbol eps
module cfo_avg_acc
    import ofdm_pkg::*;
#(
    parameter int EXT_W = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     add,
    input  logic                     fin,
    input  logic signed [DATA_W-1:0] din,
    input  logic [1:0]               shift,
    output logic                     avg_valid,
    output logic signed [DATA_W-1:0] avg_eps
);

    localparam int ACC_W = DATA_W + EXT_W;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;

    always_comb begin
        acc_next = acc;
        if (add) begin
            acc_next = acc + {{EXT_W{din[DATA_W-1]}}, din};
        end
    end

    // fin arrives with the final add, so the average is taken from acc_next
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            avg_valid <= 1'b0;
            avg_eps   <= '0;
        end else begin
            avg_valid <= fin;
            acc       <= clr ? '0 : acc_next;
            if (fin) begin
                avg_eps <= DATA_W'(acc_next >>> shift);
            end
        end
    end

endmodule

// File: rtl/cfo_est_sequencer.sv
// rtl/cfo_est_sequencer.sv - frames 2-antenna symbols for the MRC CFO estimator and averages its results
module cfo_est_sequencer
    import ofdm_pkg::*;
#(
    parameter int MAX_LOG2_NSYM = 3,
    parameter int TIMEOUT       = 32
) (
    input  logic                clk,
    input  logic                rst,
    cfo_est_sequencer_if.master bus
);

    localparam int SC_W  = $clog2(SYM_LEN);
    localparam int TO_W  = $clog2(TIMEOUT);
    localparam int SYM_W = (MAX_LOG2_NSYM > 0) ? MAX_LOG2_NSYM : 1;
    localparam logic [SC_W-1:0] SAMP_LAST = SC_W'(SYM_LEN - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);

    seq_state_t       state;
    logic [SC_W-1:0]  samp_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [SYM_W-1:0] sym_cnt;
    logic [SYM_W-1:0] nsym_m1;
    logic [1:0]       log2_nsym;
    logic             accepted;
    logic             start_ok;
    logic             res_ok;
    logic             last_sym;

    assign bus.s_ready = (state == RUN);
    assign bus.busy    = (state != IDLE);
    assign accepted    = bus.s_valid && bus.s_ready;
    assign start_ok    = (state == IDLE) && bus.start;
    assign res_ok      = (state == WAIT_RES) && bus.est_cfo_valid;
    assign nsym_m1     = SYM_W'((32'd1 << log2_nsym) - 32'd1);
    assign last_sym    = (sym_cnt == nsym_m1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= IDLE;
            samp_cnt             <= '0;
            to_cnt               <= '0;
            sym_cnt              <= '0;
            log2_nsym            <= '0;
            bus.err_timeout      <= 1'b0;
            bus.est_in_valid     <= 1'b0;
            bus.est_symbol_start <= 1'b0;
            bus.est_rx1_re       <= '0;
            bus.est_rx1_im       <= '0;
            bus.est_rx2_re       <= '0;
            bus.est_rx2_im       <= '0;
        end else begin
            bus.est_in_valid     <= accepted;
            bus.est_symbol_start <= accepted && (samp_cnt == '0);
            if (accepted) begin
                bus.est_rx1_re <= bus.s_rx1_re;
                bus.est_rx1_im <= bus.s_rx1_im;
                bus.est_rx2_re <= bus.s_rx2_re;
                bus.est_rx2_im <= bus.s_rx2_im;
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state           <= RUN;
                        log2_nsym       <= (32'(bus.cfg_log2_nsym) > 32'(MAX_LOG2_NSYM))
                                           ? 2'(MAX_LOG2_NSYM) : bus.cfg_log2_nsym;
                        samp_cnt        <= '0;
                        sym_cnt         <= '0;
                        to_cnt          <= '0;
                        bus.err_timeout <= 1'b0;
                    end
                end
                RUN: begin
                    if (accepted) begin
                        if (samp_cnt == SAMP_LAST) begin
                            samp_cnt <= '0;
                            to_cnt   <= '0;
                            state    <= WAIT_RES;
                        end else begin
                            samp_cnt <= samp_cnt + SC_W'(1);
                        end
                    end
                end
                WAIT_RES: begin
                    // a result arriving on the last timeout cycle still counts
                    if (bus.est_cfo_valid) begin
                        to_cnt <= '0;
                        if (last_sym) begin
                            state <= DONE;
                        end else begin
                            sym_cnt <= sym_cnt + SYM_W'(1);
                            state   <= RUN;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        bus.err_timeout <= 1'b1;
                        state           <= ERR;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    cfo_avg_acc #(
        .EXT_W (SYM_W)
    ) u_avg (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_ok),
        .add       (res_ok),
        .fin       (res_ok && last_sym),
        .din       (bus.est_cfo_eps),
        .shift     (log2_nsym),
        .avg_valid (bus.avg_valid),
        .avg_eps   (bus.avg_eps)
    );

endmodule

// File: tb/tb_cfo_est_sequencer.sv
// tb/tb_cfo_est_sequencer.sv - scoreboard bench for cfo_est_sequencer with a 3-cycle estimator model
module tb_cfo_est_sequencer;
    import ofdm_pkg::*;

    localparam int TIMEOUT = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cfo_est_sequencer_if bus ();

    cfo_est_sequencer #(
        .MAX_LOG2_NSYM (3),
        .TIMEOUT       (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int          eps_q[$];
    int          exp_q[$];
    logic [63:0] smp_q[$];

    bit est_mute = 1'b0;
    bit spur_en  = 1'b0;

    int inv_cnt, av_cnt, ss_cnt, rx_err, ss_err, sready_err;
    int cyc        = 0;
    int wait_entry = 0;
    int beat_idx   = 0;
    bit awaiting   = 1'b0;
    bit prev_av    = 1'b0;
    bit prev_err   = 1'b0;

    task automatic check(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // estimator model: answers 3 cycles after the 80th est_in_valid of a symbol
    initial begin
        int bcnt;
        int cd;
        bcnt = 0;
        cd   = 0;
        bus.est_cfo_valid = 1'b0;
        bus.est_cfo_eps   = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.est_cfo_valid = 1'b0;
            if (rst) begin
                bcnt = 0;
                cd   = 0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0 && !est_mute && eps_q.size() > 0) begin
                        bus.est_cfo_valid = 1'b1;
                        bus.est_cfo_eps   = 16'(eps_q.pop_front());
                    end
                end else if (spur_en && bus.s_ready && $urandom_range(0, 15) == 0) begin
                    bus.est_cfo_valid = 1'b1;
                    bus.est_cfo_eps   = 16'sd1000;
                end
                if (bus.est_in_valid) begin
                    bcnt++;
                    if (bcnt == SYM_LEN) begin
                        bcnt = 0;
                        cd   = 3;
                    end
                end
            end
        end
    end

    // monitor
    initial begin
        logic [63:0] smp;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                beat_idx = 0;
                awaiting = 1'b0;
                prev_av  = 1'b0;
                prev_err = 1'b0;
            end else begin
                if (bus.est_in_valid) begin
                    if (smp_q.size() == 0) rx_err++;
                    else begin
                        smp = smp_q.pop_front();
                        if ({bus.est_rx1_re, bus.est_rx1_im, bus.est_rx2_re, bus.est_rx2_im} !== smp) rx_err++;
                    end
                    if (bus.est_symbol_start !== (beat_idx == 0)) ss_err++;
                    if (bus.est_symbol_start) ss_cnt++;
                    inv_cnt++;
                    beat_idx = (beat_idx == SYM_LEN - 1) ? 0 : beat_idx + 1;
                    if (beat_idx == 0) begin
                        awaiting   = 1'b1;
                        wait_entry = cyc;
                    end
                end else if (bus.est_symbol_start) begin
                    ss_err++;
                end
                if (awaiting && bus.s_ready) sready_err++;
                if (bus.est_cfo_valid || !bus.busy) awaiting = 1'b0;
                if (bus.avg_valid) begin
                    av_cnt++;
                    if (exp_q.size() == 0) check("avg_unexpected", bus.avg_valid, 0);
                    else check("avg_eps", bus.avg_eps, exp_q.pop_front());
                end
                if (prev_av) check("busy_after_done", bus.busy, 0);
                if (bus.err_timeout && !prev_err) check("timeout_latency", cyc - wait_entry, TIMEOUT);
                prev_av  = bus.avg_valid;
                prev_err = bus.err_timeout;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, {bus.s_ready, bus.est_in_valid, bus.est_symbol_start,
                               bus.avg_valid, bus.busy, bus.err_timeout}, 0);
        check({tag, "_rx"}, {bus.est_rx1_re, bus.est_rx1_im, bus.est_rx2_re, bus.est_rx2_im}, 0);
        check({tag, "_avg"}, bus.avg_eps, 0);
    endtask

    task automatic run_case(input logic [1:0] cfg, input bit mute, input bit rnd,
                            input int abort_at, input bit chk_clr);
        int nsym, sum, sent, cyc_n;
        bit aborted;
        nsym = 1 << cfg;
        sum  = 0;
        foreach (eps_q[i]) sum += eps_q[i];
        if (!mute && abort_at == 0) exp_q.push_back(floor_div(sum, nsym));
        est_mute   = mute;
        spur_en    = rnd;
        inv_cnt    = 0;
        av_cnt     = 0;
        ss_cnt     = 0;
        rx_err     = 0;
        ss_err     = 0;
        sready_err = 0;
        sent       = 0;
        cyc_n      = 0;
        aborted    = 1'b0;
        @(negedge clk);
        bus.cfg_log2_nsym = cfg;
        bus.start         = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        if (chk_clr) check("err_cleared_on_start", bus.err_timeout, 0);
        while (bus.busy && cyc_n < 4000) begin
            bus.s_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.s_rx1_re = 16'($urandom);
            bus.s_rx1_im = 16'($urandom);
            bus.s_rx2_re = 16'($urandom);
            bus.s_rx2_im = 16'($urandom);
            if (rnd && $urandom_range(0, 9) == 0) begin
                bus.start         = 1'b1;
                bus.cfg_log2_nsym = 2'd0;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.s_valid && bus.s_ready) begin
                smp_q.push_back({bus.s_rx1_re, bus.s_rx1_im, bus.s_rx2_re, bus.s_rx2_im});
                sent++;
            end
            if (abort_at > 0 && sent == abort_at && !bus.s_ready) begin
                aborted = 1'b1;
                break;
            end
            @(negedge clk);
            cyc_n++;
        end
        bus.s_valid = 1'b0;
        bus.start   = 1'b0;
        if (aborted) begin
            #2 rst = 1'b1;
            #1;
            check_all_zero("rst_async");
            smp_q.delete();
            eps_q.delete();
            exp_q.delete();
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
        end else begin
            @(negedge clk);
            check("run_idle", bus.busy, 0);
            check("est_in_valid_count", inv_cnt, SYM_LEN * nsym);
            check("symbol_start_count", ss_cnt, nsym);
            check("symbol_start_pos", ss_err, 0);
            check("rx_passthru", rx_err, 0);
            check("s_ready_in_wait", sready_err, 0);
            check("avg_valid_pulses", av_cnt, mute ? 0 : 1);
            check("scoreboard_drained", exp_q.size(), 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.start         = 1'b0;
        bus.cfg_log2_nsym = 2'd0;
        bus.s_valid       = 1'b0;
        bus.s_rx1_re      = '0;
        bus.s_rx1_im      = '0;
        bus.s_rx2_re      = '0;
        bus.s_rx2_im      = '0;
        #2 rst = 1'b1;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        eps_q = '{100, 102, 98, 104};
        run_case(2'd2, 1'b0, 1'b0, 0, 1'b0);

        eps_q = '{-37};
        run_case(2'd0, 1'b0, 1'b0, 0, 1'b0);

        eps_q = '{-3, -4};
        run_case(2'd1, 1'b0, 1'b0, 0, 1'b0);

        eps_q.delete();
        run_case(2'd0, 1'b1, 1'b0, 0, 1'b0);
        check("err_sticky", bus.err_timeout, 1);
        check("avg_held_after_err", bus.avg_eps, -4);

        eps_q.delete();
        for (int i = 0; i < 8; i++) eps_q.push_back(int'($urandom_range(0, 400)) - 200);
        run_case(2'd3, 1'b0, 1'b1, 0, 1'b1);

        eps_q = '{100, 102, 98, 104};
        run_case(2'd2, 1'b0, 1'b0, 2 * SYM_LEN, 1'b0);
        eps_q = '{100, 102, 98, 104};
        run_case(2'd2, 1'b0, 1'b0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
